// File: rtl/bounce_gen_pkg.sv
// bounce_gen_pkg: FSM states, LFSR constants and counter sizing shared by bounce_generator.
package bounce_gen_pkg;
   typedef enum logic {IDLE, BOUNCE} state_t;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   // Bits needed to hold max_val itself, never less than one.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction
endpackage

// File: rtl/bounce_generator_if.sv
// bounce_generator_if: ideal switch level in, emulated bouncing contact and burst status out.
interface bounce_generator_if;
   logic clean_in;
   logic noisy_out;
   logic busy;
   logic done;
   modport master (output clean_in, input noisy_out, busy, done);
   modport slave (input clean_in, output noisy_out, busy, done);
endinterface

// File: rtl/lfsr16.sv
// lfsr16: 16-bit right-shifting Galois LFSR that advances once per cycle with step high.
module lfsr16
   import bounce_gen_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        step,
   output logic [15:0] value
);
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) value <= LFSR_SEED;
      else if (step) value <= value[0] ? (value >> 1) ^ LFSR_TAPS : value >> 1;
endmodule

// File: rtl/bounce_generator.sv
// bounce_generator: turns clean level changes into timed bursts of contact bounce.
// Define BOUNCE_GEN_LFSR_EN to add pseudo-random jitter to the toggle interval.
module bounce_generator
   import bounce_gen_pkg::*;
#(
   parameter int BOUNCE_WINDOW = 2_000_000,
   parameter int TOGGLE_PERIOD = 50_000,
   parameter int JITTER_BITS   = 12
)(
   input logic               clk,
   input logic               reset_n,
   bounce_generator_if.slave bus
);
`ifdef BOUNCE_GEN_LFSR_EN
   localparam int IMAX = TOGGLE_PERIOD - 1 + (2 ** JITTER_BITS) - 1;
`else
   localparam int IMAX = TOGGLE_PERIOD - 1;
`endif
   localparam int WW = cnt_width(BOUNCE_WINDOW - 1);
   localparam int IW = cnt_width(IMAX);
   state_t        r_state;
   logic          r_target;
   logic          r_noisy;
   logic          r_done;
   logic [WW-1:0] r_win;
   logic [IW-1:0] r_int;
   logic [IW-1:0] w_iv_m1;
   logic          w_change;
   logic          w_toggle;
   assign w_change = bus.clean_in != r_target;
   // A level change restarts the burst and pre-empts both window end and toggle.
   assign w_toggle = (r_state == BOUNCE) && !w_change && (r_win != '0) && (r_int == '0);
`ifdef BOUNCE_GEN_LFSR_EN
   logic [15:0] w_lfsr;
   logic        w_reload;
   assign w_reload = w_change || w_toggle;
   lfsr16 u_lfsr (.clk(clk), .reset_n(reset_n), .step(w_reload), .value(w_lfsr));
   assign w_iv_m1 = IW'(TOGGLE_PERIOD - 1) + IW'(w_lfsr[JITTER_BITS-1:0]);
`else
   assign w_iv_m1 = IW'(TOGGLE_PERIOD - 1);
`endif
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         r_state  <= IDLE;
         r_target <= 1'b0;
         r_noisy  <= 1'b0;
         r_done   <= 1'b0;
         r_win    <= '0;
         r_int    <= '0;
      end else begin
         r_done <= 1'b0;
         if (w_change) begin
            r_state  <= BOUNCE;
            r_target <= bus.clean_in;
            r_win    <= WW'(BOUNCE_WINDOW - 1);
            r_int    <= w_iv_m1;
         end else if (r_state == IDLE) r_noisy <= r_target;
         else if (r_win == '0) begin
            r_state <= IDLE;
            r_noisy <= r_target;
            r_done  <= 1'b1;
         end else begin
            r_win   <= r_win - WW'(1);
            r_int   <= w_toggle ? w_iv_m1 : r_int - IW'(1);
            r_noisy <= w_toggle ? ~r_noisy : r_noisy;
         end
      end
   assign bus.noisy_out = r_noisy;
   assign bus.busy      = r_state == BOUNCE;
   assign bus.done      = r_done;
endmodule

// File: tb/tb_bounce_generator.sv
// tb_bounce_generator: two instances (toggle period 3 and 4) checked against a phase-based burst model.
module tb_bounce_generator;
   import bounce_gen_pkg::*;
   localparam int W  = 20;
   localparam int P0 = 3;
   localparam int P1 = 4;
   localparam int J  = 4;
   typedef struct {int inst; int lo; int hi; logic n; logic b; logic d;} seg_t;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic clean = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;
   logic m_act [2];
   logic m_lvl [2];
   logic m_tgt [2];
   logic m_done [2];
   int   m_ph [2];
   int   m_nt [2];
`ifdef BOUNCE_GEN_LFSR_EN
   logic [15:0] m_lfsr [2];
   logic        rec [2][30];
`else
   seg_t segs [16];
`endif
   logic [1:0] w_n, w_b, w_d;
   always #5 clk = ~clk;
   bounce_generator_if if3 ();
   bounce_generator_if if4 ();
   assign if3.clean_in = clean;
   assign if4.clean_in = clean;
   assign w_n = {if4.noisy_out, if3.noisy_out};
   assign w_b = {if4.busy, if3.busy};
   assign w_d = {if4.done, if3.done};
   bounce_generator #(.BOUNCE_WINDOW(W), .TOGGLE_PERIOD(P0), .JITTER_BITS(J)) dut3 (.clk(clk), .reset_n(reset_n), .bus(if3));
   bounce_generator #(.BOUNCE_WINDOW(W), .TOGGLE_PERIOD(P1), .JITTER_BITS(J)) dut4 (.clk(clk), .reset_n(reset_n), .bus(if4));
   // Burst model: phase counts cycles since the (re)start edge; toggles land at cumulative interval sums.
   function automatic int next_iv(input int i);
      int p = (i == 0) ? P0 : P1;
`ifdef BOUNCE_GEN_LFSR_EN
      p += int'(m_lfsr[i][J-1:0]);
      m_lfsr[i] = m_lfsr[i][0] ? (m_lfsr[i] >> 1) ^ LFSR_TAPS : m_lfsr[i] >> 1;
`endif
      return p;
   endfunction
   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_act[i] = 1'b0; m_lvl[i] = 1'b0; m_tgt[i] = 1'b0; m_done[i] = 1'b0;
         m_ph[i] = 0; m_nt[i] = 0;
`ifdef BOUNCE_GEN_LFSR_EN
         m_lfsr[i] = LFSR_SEED;
`endif
      end
   endtask
   task automatic model_edge();
      if (!reset_n) model_reset();
      else for (int i = 0; i < 2; i++) begin
         m_done[i] = 1'b0;
         if (clean != m_tgt[i]) begin
            m_tgt[i] = clean; m_act[i] = 1'b1; m_ph[i] = 0; m_nt[i] = next_iv(i);
         end else if (m_act[i]) begin
            m_ph[i]++;
            if (m_ph[i] == W) begin
               m_act[i] = 1'b0; m_lvl[i] = m_tgt[i]; m_done[i] = 1'b1;
            end else if (m_ph[i] == m_nt[i]) begin
               m_lvl[i] = ~m_lvl[i]; m_nt[i] += next_iv(i);
            end
         end else m_lvl[i] = m_tgt[i];
      end
   endtask
   task automatic chk(input string nm, input logic a, input logic e);
      n_chk++;
      if (a !== e) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", nm, a, e);
      end
   endtask
   task automatic chk_int(input string nm, input int a, input int e);
      n_chk++;
      if (a != e) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, a, e);
      end
   endtask
   task automatic check_all(input string tag);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("%s.noisy%0d", tag, i), w_n[i], m_lvl[i]);
         chk($sformatf("%s.busy%0d", tag, i), w_b[i], m_act[i]);
         chk($sformatf("%s.done%0d", tag, i), w_d[i], m_done[i]);
      end
   endtask
   task automatic tick(input string tag);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all(tag);
   endtask
   task automatic async_reset(input string tag);
      reset_n = 1'b0;
      #1;
      model_reset();
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("%s.noisy%0d", tag, i), w_n[i], 1'b0);
         chk($sformatf("%s.busy%0d", tag, i), w_b[i], 1'b0);
         chk($sformatf("%s.done%0d", tag, i), w_d[i], 1'b0);
      end
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   initial begin
      int ndone;
      int last;
      model_reset();
      repeat (3) tick("reset");
      reset_n = 1'b1;
      repeat (3) tick("idle");
`ifdef BOUNCE_GEN_LFSR_EN
      for (int run = 0; run < 2; run++) begin
         clean = 1'b0;
         async_reset("lfsr_rst");
         repeat (2) tick("lfsr_rst");
         reset_n = 1'b1;
         repeat (2) tick("lfsr_idle");
         clean = 1'b1;
         last = 0;
         for (int r = 0; r < 30; r++) begin
            tick("lfsr_run");
            rec[run][r] = w_n[0];
            if (r > 0 && rec[run][r] != rec[run][r-1] && w_b[0]) begin
               chk_int($sformatf("lfsr_iv_range.r%0d", r), int'((r - last) >= P0 && (r - last) <= P0 + 15), 1);
               last = r;
            end
         end
      end
      for (int r = 0; r < 30; r++) chk($sformatf("lfsr_repeat.r%0d", r), rec[1][r], rec[0][r]);
`else
      segs[0]  = '{0, 0, 2, 1'b0, 1'b1, 1'b0};
      segs[1]  = '{0, 3, 5, 1'b1, 1'b1, 1'b0};
      segs[2]  = '{0, 6, 8, 1'b0, 1'b1, 1'b0};
      segs[3]  = '{0, 9, 11, 1'b1, 1'b1, 1'b0};
      segs[4]  = '{0, 12, 14, 1'b0, 1'b1, 1'b0};
      segs[5]  = '{0, 15, 17, 1'b1, 1'b1, 1'b0};
      segs[6]  = '{0, 18, 19, 1'b0, 1'b1, 1'b0};
      segs[7]  = '{0, 20, 20, 1'b1, 1'b0, 1'b1};
      segs[8]  = '{0, 21, 25, 1'b1, 1'b0, 1'b0};
      segs[9]  = '{1, 0, 3, 1'b0, 1'b1, 1'b0};
      segs[10] = '{1, 4, 7, 1'b1, 1'b1, 1'b0};
      segs[11] = '{1, 8, 11, 1'b0, 1'b1, 1'b0};
      segs[12] = '{1, 12, 15, 1'b1, 1'b1, 1'b0};
      segs[13] = '{1, 16, 19, 1'b0, 1'b1, 1'b0};
      segs[14] = '{1, 20, 20, 1'b1, 1'b0, 1'b1};
      segs[15] = '{1, 21, 25, 1'b1, 1'b0, 1'b0};
      clean = 1'b1;
      for (int r = 0; r <= 25; r++) begin
         tick("rise");
         foreach (segs[s]) if (r >= segs[s].lo && r <= segs[s].hi) begin
            chk($sformatf("seg%0d.r%0d.noisy", s, r), w_n[segs[s].inst], segs[s].n);
            chk($sformatf("seg%0d.r%0d.busy", s, r), w_b[segs[s].inst], segs[s].b);
            chk($sformatf("seg%0d.r%0d.done", s, r), w_d[segs[s].inst], segs[s].d);
         end
      end
      clean = 1'b0;
      repeat (25) tick("fall");
      clean = 1'b1;
      repeat (11) tick("restart_pre");
      clean = 1'b0;
      ndone = 0;
      for (int k = 1; k <= 25; k++) begin
         tick("restart");
         ndone += int'(w_d[0]);
         if (k == 20) chk("restart_busy_k20", w_b[0], 1'b1);
         if (k == 21) begin
            chk("restart_noisy_k21", w_n[0], 1'b0);
            chk("restart_done_k21", w_d[0], 1'b1);
         end
      end
      chk_int("restart_done_count", ndone, 1);
      clean = 1'b1;
      repeat (8) tick("midrst_pre");
      async_reset("midrst");
      ndone = 0;
      for (int k = 0; k < 3; k++) begin
         tick("midrst_hold");
         ndone += int'(w_d[0]) + int'(w_d[1]);
      end
      chk_int("midrst_done_count", ndone, 0);
      reset_n = 1'b1;
      tick("release");
      chk("release_busy3", w_b[0], 1'b1);
      chk("release_busy4", w_b[1], 1'b1);
      repeat (22) tick("release_run");
`endif
      reset_n = 1'b1;
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 24) == 0) clean = ~clean;
         if (!reset_n) reset_n = 1'b1;
         else if ($urandom_range(0, 149) == 0) async_reset("rnd_rst");
         tick("rnd");
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
